// File: rtl/pwm_breath_pkg.sv
// rtl/pwm_breath_pkg.sv - shared mode encoding and counter sizing for the breathing-LED PWM block
package pwm_breath_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_ON     = 2'b01,
        MODE_BREATH = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_t;

    // Counter width for values 0..range-1, never narrower than one bit.
    function automatic int cnt_w(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/pwm_breath_if.sv
// rtl/pwm_breath_if.sv - mode/LED/ramp bundle of pwm_breath_ctrl with controller and LED-side modports
interface pwm_breath_if #(
    parameter int CH_NUM = 4
);
    logic [2*CH_NUM-1:0] mode;
    logic [CH_NUM-1:0]   led_out;
    logic                ramp_done;

    modport master (output mode, input led_out, input ramp_done);
    modport slave  (input mode, output led_out, output ramp_done);
endinterface

// File: rtl/pwm_breath_ch.sv
// rtl/pwm_breath_ch.sv - one LED channel: mode register, triangle level, PWM compare, output flop
// BREATH_PHASE_EN: when defined, channel CH_IDX runs its breath position shifted by CH_IDX*(2*STEPS/CH_NUM).
module pwm_breath_ch
    import pwm_breath_pkg::*;
#(
    parameter int CH_IDX         = 0,
    parameter int CH_NUM         = 4,
    parameter int STEPS          = 1000,
    parameter int LED_ACTIVE_LOW = 1,
    parameter int CW             = cnt_w(STEPS),
    parameter int PW             = cnt_w(2*STEPS)
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          period_end,
    input  logic [CW-1:0] pwm_cnt,
    input  logic [PW-1:0] pos,
    input  logic [1:0]    mode_in,
    output logic          led
);

`ifdef BREATH_PHASE_EN
    localparam bit PHASE_EN = 1'b1;
`else
    localparam bit PHASE_EN = 1'b0;
`endif
    localparam int   PHASE_OFS = PHASE_EN ? CH_IDX * ((2*STEPS) / CH_NUM) : 0;
    localparam logic UNLIT     = (LED_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    mode_t         mode_q, mode_d;
    logic          led_q, led_d;
    logic [PW:0]   pos_sum;
    logic [PW-1:0] pos_k;
    logic [PW-1:0] lvl;
    logic          rising;
    logic          lit;

    always_comb begin
        pos_sum = {1'b0, pos} + (PW+1)'(PHASE_OFS);
        // Offset is below 2*STEPS, so one conditional subtract completes the modulo.
        pos_k   = (pos_sum >= (PW+1)'(2*STEPS)) ? PW'(pos_sum - (PW+1)'(2*STEPS))
                                                : pos_sum[PW-1:0];
        rising  = (pos_k < PW'(STEPS));
        lvl     = rising ? pos_k : PW'(2*STEPS-1) - pos_k;

        lit = 1'b0;
        case (mode_q)
            MODE_OFF:    lit = 1'b0;
            MODE_ON:     lit = 1'b1;
            MODE_BREATH: lit = (PW'(pwm_cnt) < lvl);
            MODE_BLINK:  lit = rising;
            default:     lit = 1'b0;
        endcase

        led_d  = lit ? ~UNLIT : UNLIT;
        mode_d = period_end ? mode_t'(mode_in) : mode_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q <= MODE_OFF;
            led_q  <= UNLIT;
        end else begin
            mode_q <= mode_d;
            led_q  <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/pwm_breath_ctrl.sv
// rtl/pwm_breath_ctrl.sv - multi-channel breathing/blinking LED PWM controller with shared timebase
// BREATH_PHASE_EN: when defined, channels breathe with evenly spread phase offsets.
module pwm_breath_ctrl
    import pwm_breath_pkg::*;
#(
    parameter int CH_NUM         = 4,
    parameter int TICK_MAX       = 49,
    parameter int STEPS          = 1000,
    parameter int LED_ACTIVE_LOW = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [2*CH_NUM-1:0] mode,
    output logic [CH_NUM-1:0]   led_out,
    output logic                ramp_done
);

    localparam int TW = cnt_w(TICK_MAX + 1);
    localparam int CW = cnt_w(STEPS);
    localparam int PW = cnt_w(2*STEPS);

    logic [TW-1:0] tick_q, tick_d;
    logic [CW-1:0] pwm_q, pwm_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          ramp_done_q, ramp_done_d;
    logic          tick_end;
    logic          period_end;

    always_comb begin
        tick_end    = (tick_q == TW'(TICK_MAX));
        period_end  = tick_end && (pwm_q == CW'(STEPS-1));

        tick_d      = tick_end ? '0 : tick_q + TW'(1);

        pwm_d       = pwm_q;
        if (tick_end) begin
            pwm_d = (pwm_q == CW'(STEPS-1)) ? '0 : pwm_q + CW'(1);
        end

        pos_d       = pos_q;
        if (period_end) begin
            pos_d = (pos_q == PW'(2*STEPS-1)) ? '0 : pos_q + PW'(1);
        end

        // Always tied to the unshifted position, whatever the channel phasing.
        ramp_done_d = period_end && (pos_q == PW'(2*STEPS-1));
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_q      <= '0;
            pwm_q       <= '0;
            pos_q       <= '0;
            ramp_done_q <= 1'b0;
        end else begin
            tick_q      <= tick_d;
            pwm_q       <= pwm_d;
            pos_q       <= pos_d;
            ramp_done_q <= ramp_done_d;
        end
    end

    assign ramp_done = ramp_done_q;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        pwm_breath_ch #(
            .CH_IDX        (k),
            .CH_NUM        (CH_NUM),
            .STEPS         (STEPS),
            .LED_ACTIVE_LOW(LED_ACTIVE_LOW),
            .CW            (CW),
            .PW            (PW)
        ) u_ch (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .period_end(period_end),
            .pwm_cnt   (pwm_q),
            .pos       (pos_q),
            .mode_in   (mode[2*k +: 2]),
            .led       (led_out[k])
        );
    end

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
// tb/tb_pwm_breath_ctrl.sv - scoreboard bench for pwm_breath_ctrl (CH_NUM=2, TICK_MAX=1, STEPS=4, active-low)
module tb_pwm_breath_ctrl;

    localparam int CH_NUM   = 2;
    localparam int TICK_MAX = 1;
    localparam int STEPS    = 4;
    localparam int TPER     = TICK_MAX + 1;
    localparam int PPER     = TPER * STEPS;
    localparam int BPER     = PPER * 2 * STEPS;
`ifdef BREATH_PHASE_EN
    localparam int PH_EN = 1;
`else
    localparam int PH_EN = 0;
`endif

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    pwm_breath_if #(.CH_NUM(CH_NUM)) bus ();

    pwm_breath_ctrl #(
        .CH_NUM        (CH_NUM),
        .TICK_MAX      (TICK_MAX),
        .STEPS         (STEPS),
        .LED_ACTIVE_LOW(1)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .mode     (bus.mode),
        .led_out  (bus.led_out),
        .ramp_done(bus.ramp_done)
    );

    always #5 sys_clk = ~sys_clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc;
    logic [3:0] mdl_mode;
    logic [3:0] cur_mode;
    logic [1:0] per_m1;
    logic [2:0] exp_q [$];
    int         lit_cnt;
    int         first_ramp;
    int         last_ramp;
    int         lit_tab [8] = '{0, 2, 4, 6, 6, 4, 2, 0};

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int lvl_of(input int p);
        return (p < STEPS) ? p : 2*STEPS - 1 - p;
    endfunction

    // Expected {ramp_done, led_out} after rising edge c (edges counted from reset release).
    function automatic logic [2:0] model(input int c, input logic [3:0] m);
        int         p, pw, pk;
        logic       lit;
        logic [1:0] led;
        logic [1:0] mk;
        p  = (c / PPER) % (2*STEPS);
        pw = (c / TPER) % STEPS;
        for (int k = 0; k < CH_NUM; k++) begin
            pk = (p + PH_EN * k * ((2*STEPS) / CH_NUM)) % (2*STEPS);
            mk = m[2*k +: 2];
            case (mk)
                2'b00:   lit = 1'b0;
                2'b01:   lit = 1'b1;
                2'b10:   lit = (pw < lvl_of(pk));
                default: lit = (pk < STEPS);
            endcase
            led[k] = ~lit;
        end
        return {((c % BPER) == BPER - 1), led};
    endfunction

    task automatic step();
        logic [2:0] e;
        int         p;
        @(posedge sys_clk);
        if (cyc % PPER == 0) per_m1 = mdl_mode[3:2];
        cur_mode = mdl_mode;
        exp_q.push_back(model(cyc, mdl_mode));
        if (cyc % PPER == PPER - 1) mdl_mode = bus.mode;
        cyc++;
        @(negedge sys_clk);
        e = exp_q.pop_front();
        check_eq("led_out", bus.led_out, e[1:0]);
        check_eq("ramp_done", bus.ramp_done, e[2]);
        if (bus.ramp_done) begin
            if (first_ramp < 0) first_ramp = cyc - 1;
            else check_eq("ramp_interval", cyc - 1 - last_ramp, BPER);
            last_ramp = cyc - 1;
        end
        if (cur_mode == 4'b1111) check_eq("blink_phase", bus.led_out[0] ^ bus.led_out[1], PH_EN);
        if (!bus.led_out[1]) lit_cnt++;
        if ((cyc - 1) % PPER == PPER - 1) begin
            p = ((cyc - 1) / PPER) % (2*STEPS);
            if (per_m1 == 2'b10) check_eq("ch1_breath_clk", lit_cnt, lit_tab[(p + 4*PH_EN) % 8]);
            else if (per_m1 == 2'b00) check_eq("ch1_off_clk", lit_cnt, 0);
            lit_cnt = 0;
        end
    endtask

    initial begin
        bus.mode   = 4'b0110;
        cyc        = 0;
        mdl_mode   = 4'b0000;
        cur_mode   = 4'b0000;
        per_m1     = 2'b00;
        lit_cnt    = 0;
        first_ramp = -1;
        last_ramp  = 0;

        repeat (3) begin
            @(negedge sys_clk);
            check_eq("rst_led", bus.led_out, 3);
            check_eq("rst_ramp", bus.ramp_done, 0);
        end
        sys_rst_n = 1'b1;

        repeat (140) step();
        check_eq("first_ramp_edge", first_ramp, BPER - 1);

        // Mid-period switch of channel 1 from BREATH to OFF while L=2.
        while (cyc % BPER != 2*PPER + 3) step();
        bus.mode = 4'b0001;
        repeat (24) step();

        bus.mode = 4'b1111;
        repeat (80) step();

        // Reset while P=5, partway through the period.
        bus.mode = 4'b0110;
        while (cyc % BPER != 5*PPER + 3) step();
        #2 sys_rst_n = 1'b0;
        #1;
        check_eq("async_rst_led", bus.led_out, 3);
        check_eq("async_rst_ramp", bus.ramp_done, 0);
        @(negedge sys_clk);
        check_eq("held_rst_led", bus.led_out, 3);
        sys_rst_n = 1'b1;
        cyc       = 0;
        mdl_mode  = 4'b0000;
        lit_cnt   = 0;
        exp_q.delete();
        repeat (24) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_breath_ctrl.md
PWM_BREATH_CTRL -- requirements
Module: pwm_breath_ctrl

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, meaning number of independent LED channels (1..16).
REQ-002 SHALL have parameter TICK_MAX, default 49, meaning sys_clk cycles per PWM tick minus one (50 MHz -> 1 us).
REQ-003 SHALL have parameter STEPS, default 1000, meaning PWM ticks per PWM period, equal to the number of duty levels (minimum 2).
REQ-004 SHALL have parameter LED_ACTIVE_LOW, default 1, meaning a lit LED is driven 0.
REQ-005 SHALL have port sys_clk, input, 1 bit, meaning system clock, with all logic on its rising edge.
REQ-006 SHALL have port sys_rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-007 SHALL have port mode, input, 2*CH_NUM bits, meaning per-channel mode; bits [2k+1:2k] select channel k.
REQ-008 SHALL have port led_out, output, CH_NUM bits, meaning registered per-channel LED drive.
REQ-009 SHALL have port ramp_done, output, 1 bit, meaning one-cycle pulse at the end of each full breath cycle.

Function
REQ-010 SHALL run a tick prescaler 0..TICK_MAX, wrapping to 0; tick_end is asserted when the prescaler equals TICK_MAX.
REQ-011 SHALL run a PWM counter 0..STEPS-1 that advances on tick_end and wraps; period_end = tick_end AND pwm counter equal to STEPS-1.
REQ-012 SHALL run a shared breath position P over 0..2*STEPS-1 that advances on period_end and wraps to 0.
REQ-013 SHALL compute channel level L = P when P < STEPS, else L = 2*STEPS-1-P (triangle: 0 up to STEPS-1, then back down to 0).
REQ-014 SHALL provide modes: 00 OFF (constantly unlit), 01 ON (constantly lit), 10 BREATH (lit while pwm counter < L), 11 BLINK (lit while P < STEPS).
REQ-015 SHALL sample each channel's mode into an internal register only on period_end, so that mode changes never truncate a PWM period.
REQ-016 SHALL register led_out, which lags the comparison by one sys_clk; the lit level is 0 when LED_ACTIVE_LOW=1, else 1.
REQ-017 SHALL drive BREATH at L=0 as never lit and at L=STEPS-1 as lit for STEPS-1 of STEPS ticks.
REQ-018 SHALL pulse ramp_done high for exactly one cycle, the cycle after period_end with P=2*STEPS-1.
REQ-019 SHALL size all counters with $clog2 of their range and SHALL NOT overflow at the maximum parameter values.

Reset
REQ-020 SHALL, with sys_rst_n low, clear the prescaler, PWM counter and P to 0, clear every mode register to OFF, hold ramp_done at 0, and hold every led_out bit at the unlit level.
REQ-021 SHALL force the state of REQ-020 immediately on reset assertion mid-operation; after release, it SHALL restart from P=0 with the first mode sample at the first period_end.

Configuration
REQ-022 SHALL, with macro BREATH_PHASE_EN defined, give channel k position Pk = (P + k*((2*STEPS)/CH_NUM)) mod 2*STEPS, used by BREATH and BLINK in place of P.
REQ-023 SHALL, without BREATH_PHASE_EN, have all channels use P directly and remain in phase; ramp_done SHALL always follow the unshifted P.

Structure
REQ-024 SHALL define the mode constants MODE_OFF/ON/BREATH/BLINK and the 2-bit mode typedef in shared package pwm_breath_pkg.
REQ-025 SHALL keep the prescaler, PWM counter and P at top level, and SHALL instantiate sub-module pwm_breath_ch once per channel; each instance holds its mode register, level computation and output register.

Verification
Use TICK_MAX=1, STEPS=4, CH_NUM=2 and LED_ACTIVE_LOW=1 unless stated. With these values a PWM period is 8 clk and a breath cycle is 64 clk.
REQ-026 SHALL check reset: led_out=2'b11 and ramp_done=0 during reset, and after release led_out stays 2'b11 until the first period_end.
REQ-027 SHALL check mode=4'b0110: channel 0 stays lit (0) and channel 1 lights for 0, 2, 4 and 6 clk in periods with L=0..3, then 6, 4, 2 and 0 clk, repeating.
REQ-028 SHALL check that ramp_done pulses every 64 clk, one cycle wide, first at 64 clk after release plus pipeline latency.
REQ-029 SHALL check that changing mode mid-period from BREATH to OFF keeps the current period's waveform intact, with the output unlit from the next period onward.
REQ-030 SHALL check with BREATH_PHASE_EN and both channels in BLINK that channel 1 is shifted by 4 periods (32 clk) from channel 0, i.e. the channels are exactly complementary.
REQ-031 SHALL check that asserting reset at P=5 mid-period forces outputs unlit immediately, and after release the sequence restarts at L=0.
